// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer (main + skid) under a
// valid/ready handshake. Every output is driven straight from a flop.
// Ports:
//   clk, rst (async, active-low), flush (sync squash of held entries)
//   in_valid/in_ready/in_ctrl/in_data     upstream handshake and payload
//   out_valid/out_ready/out_ctrl/out_data downstream handshake and payload
// out_ctrl reads 0 whenever out_valid is 0; out_data keeps its last value
// across bubbles unless a flush clears it (CLR_DATA_FLUSH != 0).
module pipe_stage_elastic #(
   parameter int unsigned CTRL_W         = 2,
   parameter int unsigned DATA_W         = 69,
   parameter int unsigned CLR_DATA_FLUSH = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   logic [1:0]        state_q,     state_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q,  in_ready_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              accept_c;

   // in_ready_q is low only in SKID, so no accept can happen there
   assign accept_c = in_valid & in_ready_q;

   // Next-state and payload steering
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;

      if (flush) begin
         // Squash everything, drop any same-cycle accept
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
         if (CLR_DATA_FLUSH != 0) begin
            main_data_d = '0;
            skid_data_d = '0;
         end
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  state_d     = ST_FULL;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            ST_FULL: begin
               if (accept_c && out_ready) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (accept_c) begin
                  state_d     = ST_SKID;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (out_ready) begin
                  // Bubble: control zeroed, data left as-is
                  state_d     = ST_EMPTY;
                  main_ctrl_d = '0;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  state_d     = ST_FULL;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_ctrl_d = '0;
            end
         endcase
      end

      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_SKID);
   end

   // State and payload registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two instances (data held / data cleared on
// flush) share one stimulus stream and are compared every cycle against a
// queue-based model of the words held in the stage.
module tb_pipe_stage_elastic;

   localparam int unsigned CW = 2;
   localparam int unsigned DW = 69;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } word_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          ir0, ov0, ir1, ov1;
   logic [CW-1:0] oc0, oc1;
   logic [DW-1:0] od0, od1;

   int checks = 0;
   int errors = 0;

   // Model: words currently held (head = visible word), visible data per instance
   word_t         q[$];
   logic [DW-1:0] md0, md1;
   bit            last_acc;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA_FLUSH(0)) u_hold (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0));

   pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA_FLUSH(1)) u_clr (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Compare both instances against the model
   task automatic compare_all();
      logic          ev;
      logic [CW-1:0] ec;
      ev = (q.size() > 0);
      ec = ev ? q[0].c : '0;
      chk("hold.out_valid", 128'(ov0), 128'(ev));
      chk("hold.out_ctrl",  128'(oc0), 128'(ec));
      chk("hold.out_data",  128'(od0), 128'(md0));
      chk("hold.in_ready",  128'(ir0), 128'(q.size() < 2));
      chk("clr.out_valid",  128'(ov1), 128'(ev));
      chk("clr.out_ctrl",   128'(oc1), 128'(ec));
      chk("clr.out_data",   128'(od1), 128'(md1));
      chk("clr.in_ready",   128'(ir1), 128'(q.size() < 2));
      if (!ov0) chk("hold.bubble_ctrl", 128'(oc0), 128'd0);
      if (!ov1) chk("clr.bubble_ctrl",  128'(oc1), 128'd0);
   endtask

   // One clock: update the model from pre-edge inputs, then check after the edge
   task automatic tick();
      bit    acc, emt;
      word_t w;
      acc = in_valid && (q.size() < 2);
      emt = out_ready && (q.size() > 0);
      w.c = in_ctrl;
      w.d = in_data;
      if (flush) begin
         acc = 1'b0;
         q.delete();
         md1 = '0;
      end else begin
         if (emt) void'(q.pop_front());
         if (acc) q.push_back(w);
         if (q.size() > 0) begin
            md0 = q[0].d;
            md1 = q[0].d;
         end
      end
      last_acc = acc;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   initial begin
      // 1: reset with in_valid high
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      put(2'b01, 69'h1_2345_6789_ABCD_EF01);
      q.delete(); md0 = '0; md1 = '0;
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      chk("reset.in_ready", 128'(ir0), 128'd1);
      chk("reset.out_data", 128'(od0), 128'd0);
      rst = 1'b1;
      tick();
      chk("reset.first_accept", 128'(ov0), 128'd1);

      // 2: streaming, 1-cycle latency, no gaps
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         put(2'b11, DW'(i));
         tick();
         chk("stream.data", 128'(od0), 128'(i));
         chk("stream.in_ready", 128'(ir0), 128'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream.drain_valid", 128'(ov0), 128'd0);

      // 3: backpressure A,B,C
      out_ready = 1'b0;
      put(2'b01, DW'(16'hA));  tick();
      put(2'b10, DW'(16'hB));  tick();
      chk("bp.in_ready_low", 128'(ir0), 128'd0);
      chk("bp.main_is_A", 128'(od0), 128'hA);
      put(2'b11, DW'(16'hC));  tick(); tick();
      chk("bp.C_held", 128'(last_acc), 128'd0);
      out_ready = 1'b1;
      tick();
      chk("bp.B_out", 128'(od0), 128'hB);
      tick();
      chk("bp.C_accepted", 128'(last_acc), 128'd1);
      chk("bp.C_out", 128'(od0), 128'hC);
      in_valid = 1'b0;
      tick();
      chk("bp.empty", 128'(ov0), 128'd0);

      // 4: flush while in SKID with C presented
      out_ready = 1'b0;
      put(2'b01, DW'(16'hA));  tick();
      put(2'b10, DW'(16'hB));  tick();
      put(2'b11, DW'(16'hC));  flush = 1'b1; tick();
      flush = 1'b0;
      chk("flush.out_valid", 128'(ov0), 128'd0);
      chk("flush.out_ctrl",  128'(oc0), 128'd0);
      chk("flush.in_ready",  128'(ir0), 128'd1);
      chk("flush.clr_data",  128'(od1), 128'd0);
      tick();
      chk("flush.C_alone", 128'(od0), 128'hC);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      chk("flush.C_gone", 128'(ov0), 128'd0);

      // 5: bubble control, then flush on data-clearing instance
      put(2'b11, DW'(20'h5A5A5)); tick();
      in_valid = 1'b0; tick();
      chk("bubble.ctrl",      128'(oc0), 128'd0);
      chk("bubble.data_hold", 128'(od0), 128'h5A5A5);
      chk("bubble.data_clr",  128'(od1), 128'h5A5A5);
      out_ready = 1'b0;
      put(2'b11, DW'(20'hC3C3C)); tick();
      in_valid = 1'b0; flush = 1'b1; tick();
      flush = 1'b0;
      chk("bubble.flush_hold", 128'(od0), 128'hC3C3C);
      chk("bubble.flush_clr",  128'(od1), 128'd0);

      // 6: random traffic; upstream keeps an unaccepted word stable
      in_valid = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         if (!(in_valid && !last_acc)) begin
            if ($urandom_range(0, 3) != 0) put(CW'($urandom), rnd_data());
            else in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         tick();
      end
      flush = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
